// File: rtl/rr_sum_scheduler.sv
// Round-robin scheduler sharing one NUM_OPS-operand accumulate engine between NUM_REQ requesters.
// Optional idle-operand watchdog enabled by defining RR_SUM_TIMEOUT_EN (adds TIMEOUT_CYC parameter).
module rr_sum_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int NUM_OPS = 8,
  parameter int DATA_W  = 4,
  parameter int SUM_W   = 7
`ifdef RR_SUM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [NUM_REQ-1:0]                            op_valid,
  input  logic [NUM_REQ*DATA_W-1:0]                     op_data,
  output logic [NUM_REQ-1:0]                            gnt,
  output logic                                          op_ready,
  output logic                                          res_valid,
  output logic [SUM_W-1:0]                              res_data,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] res_id,
  output logic                                          res_err,
  input  logic                                          res_ready,
  output logic                                          busy
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_OPS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   g_idx;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  op_cnt;
  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              accept;
  logic              last_op;
  logic              timeout;

  assign any_req = |req;

  // Lowest rotation offset from rr_ptr wins, so iterate from the far end downward.
  always_comb begin
    logic [ID_W:0] cand;
    winner = rr_ptr;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (req[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_idx == ID_W'(i)) begin
        g_data  = op_data[i*DATA_W +: DATA_W];
        g_valid = op_valid[i];
      end
    end
  end

  assign accept  = (state == COLLECT) && g_valid;
  assign last_op = accept && (op_cnt == CNT_W'(NUM_OPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = COLLECT;
      COLLECT: if (last_op || timeout) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == COLLECT);
    res_valid = (state == RESULT);
    busy      = (state != IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = (state == COLLECT) && (g_idx == ID_W'(i));
    end
  end

  // rr_ptr only moves on the result handshake so a stalled result never skips anyone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_idx  <= '0;
      rr_ptr <= '0;
      acc    <= '0;
      op_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            g_idx  <= winner;
            acc    <= '0;
            op_cnt <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            acc    <= acc + SUM_W'(g_data);
            op_cnt <= op_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            rr_ptr <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data = acc;
  assign res_id   = g_idx;

`ifdef RR_SUM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign timeout = (state == COLLECT) && !g_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Counts consecutive starved COLLECT cycles; any accepted operand restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            wd_cnt <= '0;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_err = err_q;
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sum_scheduler.sv
// Self-checking bench for rr_sum_scheduler: directed jobs plus a per-cycle transaction model.
module tb_rr_sum_scheduler;

  localparam int NR = 4;
  localparam int NO = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  op_valid = '0;
  logic [15:0] op_data = '0;
  logic        res_ready = 1'b0;
  logic [3:0]  gnt;
  logic        op_ready;
  logic        res_valid;
  logic [6:0]  res_data;
  logic [1:0]  res_id;
  logic        res_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  rr_sum_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .gnt       (gnt),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_ready (res_ready),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] v, input logic [15:0] d, input logic rr);
    req       = r;
    op_valid  = v;
    op_data   = d;
    res_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  function automatic int ohIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction model: who owns the engine, what it has summed, whose turn is next.
  int m_owner = -1;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_sum = 0;
  int m_taken = 0;
  int m_turn = 0;
  int m_idle = 0;

  always @(posedge clk or posedge reset) begin : model
    int c;
    bit found;
    if (reset) begin
      m_owner = -1; m_done = 0; m_err = 0; m_sum = 0; m_taken = 0; m_turn = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int d = 0; d < NR; d++) begin
        c = (m_turn + d) % NR;
        if (req[c] && !found) begin
          found = 1; m_owner = c; m_sum = 0; m_taken = 0; m_idle = 0; m_err = 0; m_done = 0;
        end
      end
    end else if (!m_done) begin
      if (op_valid[m_owner]) begin
        m_sum   = m_sum + int'(op_data[m_owner*4 +: 4]);
        m_taken = m_taken + 1;
        m_idle  = 0;
        if (m_taken == NO) m_done = 1;
      end else begin
        m_idle = m_idle + 1;
`ifdef RR_SUM_TIMEOUT_EN
        if (m_idle == TO) begin
          m_done = 1;
          m_err  = 1;
        end
`endif
      end
    end else if (res_ready) begin
      m_turn  = (m_owner + 1) % NR;
      m_owner = -1;
      m_done  = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] eg;
      eg = (m_owner >= 0 && !m_done) ? 4'(1 << m_owner) : 4'b0;
      checkOutput("m_gnt", {28'd0, gnt}, {28'd0, eg});
      checkOutput("m_op_ready", {31'd0, op_ready}, {31'd0, (m_owner >= 0 && !m_done)});
      checkOutput("m_busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
      checkOutput("m_res_valid", {31'd0, res_valid}, {31'd0, m_done});
      if (m_done) begin
        checkOutput("m_res_data", {25'd0, res_data}, m_sum);
        checkOutput("m_res_id", {30'd0, res_id}, m_owner);
        checkOutput("m_res_err", {31'd0, res_err}, {31'd0, m_err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int gl[$];
    int il[$];
    int dl[$];
    logic [3:0] prev;
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};

    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_op_ready", {31'd0, op_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", {25'd0, res_data}, 32'd0);
    checkOutput("rst_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("rst_res_err", {31'd0, res_err}, 32'd0);
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single requester, operands 1..8 back-to-back
    applyStimulus(4'b0001, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_gnt", {28'd0, gnt}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) checkOutput("t1_not_early", {31'd0, res_valid}, 32'd0);
      applyStimulus(4'b0, 4'b0001, 16'(k), 1'b0);
      tick();
    end
    checkOutput("t1_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("t1_res_data", {25'd0, res_data}, 32'd36);
    checkOutput("t1_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("t1_res_err", {31'd0, res_err}, 32'd0);
    checkOutput("t1_gnt_off", {28'd0, gnt}, 32'd0);
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b1);
    tick();
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);

    // All four requesting, full-scale operands: strict rotation from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 16'hFFFF, 1'b1);
    prev = '0;
    for (int n = 0; n < 80 && (gl.size() < 5 || il.size() < 4); n++) begin
      tick();
      if (gnt != 0 && prev == 0) gl.push_back(ohIdx(gnt));
      prev = gnt;
      if (res_valid) begin
        il.push_back(int'(res_id));
        dl.push_back(int'(res_data));
      end
    end
    checkOutput("t2_ngrants", gl.size(), 32'd5);
    checkOutput("t2_nresults", il.size(), 32'd4);
    for (int i = 0; i < gl.size() && i < 5; i++) checkOutput($sformatf("t2_grant%0d", i), gl[i], exp_g[i]);
    for (int i = 0; i < il.size() && i < 4; i++) begin
      checkOutput($sformatf("t2_id%0d", i), il[i], i);
      checkOutput($sformatf("t2_data%0d", i), dl[i], 32'd120);
    end
    applyStimulus(4'b0, 4'b1111, 16'hFFFF, 1'b1);
    waitIdle(20);
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);

    // Requester 2 with gaps while requester 1 floods op_valid
    applyStimulus(4'b0100, 4'b0010, 16'h03F0, 1'b0);
    tick();
    checkOutput("t3_gnt", {28'd0, gnt}, 32'h4);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) checkOutput("t3_not_early", {31'd0, res_valid}, 32'd0);
      applyStimulus(4'b0, 4'b0110, 16'h03F0, 1'b0);
      tick();
      if (k < 7) begin
        applyStimulus(4'b0, 4'b0010, 16'h03F0, 1'b0);
        tick();
      end
    end
    checkOutput("t3_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("t3_res_data", {25'd0, res_data}, 32'd24);
    checkOutput("t3_res_id", {30'd0, res_id}, 32'd2);
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b1);
    tick();
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);

    // Result back-pressure while another request waits
    applyStimulus(4'b1000, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t4_gnt", {28'd0, gnt}, 32'h8);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0, 4'b1000, 16'h2000, 1'b0);
      tick();
    end
    applyStimulus(4'b0010, 4'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_valid%0d", i), {31'd0, res_valid}, 32'd1);
      checkOutput($sformatf("t4_data%0d", i), {25'd0, res_data}, 32'd16);
      checkOutput($sformatf("t4_id%0d", i), {30'd0, res_id}, 32'd3);
      checkOutput($sformatf("t4_gnt%0d", i), {28'd0, gnt}, 32'd0);
      tick();
    end
    applyStimulus(4'b0010, 4'b0, 16'h0, 1'b1);
    tick();
    checkOutput("t4_gnt_idle", {28'd0, gnt}, 32'd0);
    applyStimulus(4'b0010, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t4_gnt_after", {28'd0, gnt}, 32'h2);

    // Reset mid-job, then a fresh job
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0, 4'b0010, 16'h0010, 1'b0);
      tick();
    end
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("t5_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("t5_op_ready", {31'd0, op_ready}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("t5_res_data", {25'd0, res_data}, 32'd0);
    checkOutput("t5_res_id", {30'd0, res_id}, 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(4'b0001, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t5_gnt_new", {28'd0, gnt}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0, 4'b0001, 16'h0001, 1'b0);
      tick();
    end
    checkOutput("t5_res_valid_new", {31'd0, res_valid}, 32'd1);
    checkOutput("t5_res_data_new", {25'd0, res_data}, 32'd8);
    checkOutput("t5_res_id_new", {30'd0, res_id}, 32'd0);
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b1);
    tick();
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);

`ifdef RR_SUM_TIMEOUT_EN
    // Starved job is cut off by the watchdog
    applyStimulus(4'b0010, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t6_gnt", {28'd0, gnt}, 32'h2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0, 4'b0010, 16'h0050, 1'b0);
      tick();
    end
    applyStimulus(4'b0, 4'b0, 16'h0050, 1'b0);
    repeat (TO - 1) tick();
    checkOutput("t6_not_early", {31'd0, res_valid}, 32'd0);
    tick();
    checkOutput("t6_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("t6_res_err", {31'd0, res_err}, 32'd1);
    checkOutput("t6_res_data", {25'd0, res_data}, 32'd15);
    checkOutput("t6_res_id", {30'd0, res_id}, 32'd1);
    applyStimulus(4'b0111, 4'b0, 16'h0, 1'b1);
    tick();
    applyStimulus(4'b0111, 4'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t6_next_gnt", {28'd0, gnt}, 32'h4);
    applyStimulus(4'b0, 4'b0, 16'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_sum_scheduler.md
Name: rr_sum_scheduler

Overview:
Round-robin scheduler that shares one 8-operand, 4-bit accumulate engine between several requesters.
- Grants one requester at a time.
- Streams that requester's operands into a 7-bit running sum.
- Returns the sum tagged with the requester ID over a valid/ready result port.
- Sits between the per-client input sequencers and the shared adder/accumulator datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_OPS, 8, operands per job
DATA_W, 4, operand width
SUM_W, 7, result width (must hold NUM_OPS*(2^DATA_W-1); 8*15=120 fits in 7 bits)
TIMEOUT_CYC, 16, idle-operand watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester job request, level
op_valid  in  NUM_REQ  per-requester operand valid
op_data  in  NUM_REQ*DATA_W  packed operands, requester i at [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot grant, registered
op_ready  out  1  engine accepts an operand from the granted requester this cycle
res_valid  out  1  result available
res_data  out  SUM_W  job sum
res_id  out  max(1,$clog2(NUM_REQ))  index of the requester owning res_data
res_err  out  1  job aborted by timeout (tied 0 without the optional feature)
res_ready  in  1  consumer accepts result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, gnt=0, op_ready=0, res_valid=0, res_data=0, res_id=0, res_err=0, busy=0, acc=0, op_cnt=0, rr_ptr=0.
- States: IDLE, COLLECT, RESULT.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr and wrapping at NUM_REQ.
  - Next cycle: gnt=onehot(winner), acc=0, op_cnt=0, state=COLLECT.
  - Latency from req to gnt is 1 cycle.
- COLLECT:
  - op_ready=1.
  - Accept when op_valid[g]=1 (g = granted index); then acc <= acc + zero-extended op_data[g] and op_cnt++.
  - op_valid of non-granted requesters is ignored.
  - op_valid[g]=0 stalls with no state change.
  - On the accept that makes op_cnt=NUM_OPS: next cycle state=RESULT, res_valid=1, res_data=final sum, res_id=g, gnt=0, op_ready=0.
  - Result appears 1 cycle after the last accepted operand.
- RESULT:
  - res_valid, res_data and res_id hold stable until res_ready=1.
  - On the handshake cycle: next cycle res_valid=0, rr_ptr=(g+1) mod NUM_REQ, state=IDLE.
  - A new grant cannot issue earlier than the cycle after IDLE is re-entered, so minimum job turnaround is NUM_OPS+3 cycles.
- req is sampled only in IDLE:
  - Deasserting req mid-job does not cancel the job.
  - A requester that holds req gets its next turn only after all other active requesters have been served (fairness).
- Simultaneous requests: strict rotation from rr_ptr. rr_ptr advances only on result handshake.
- Arithmetic: no overflow possible under the width rule. acc is SUM_W bits, zero-extended add, no carry-out port.
- Reset asserted mid-job: immediately return all outputs to their reset values. The partial job is discarded and not replayed.
- At most one operand is accepted per cycle. op_ready is a pure function of state (no combinational path from op_valid).

Optional Feature:
Macro RR_SUM_TIMEOUT_EN.
- With the macro:
  - A watchdog counts consecutive COLLECT cycles with op_valid[g]=0 and clears on each accept.
  - Reaching TIMEOUT_CYC forces RESULT with res_err=1, res_data=partial acc, res_id=g.
  - rr_ptr advances normally after the handshake.
- Without the macro:
  - No watchdog logic.
  - res_err is constant 0.
  - COLLECT waits indefinitely.

Test Plan:
1. After reset, req=4'b0001 and requester 0 streams 1..8 back-to-back -> gnt=0001 one cycle after req; res_valid 1 cycle after 8th accept; res_data=36, res_id=0, res_err=0.
2. req=4'b1111 held constantly, every stream is eight 4'hF, res_ready=1 -> grants in order 0,1,2,3,0; each res_data=120; res_id sequence 0,1,2,3.
3. Requester 2 streams 3 every other cycle with op_valid gaps; op_valid[1]=1 with data 4'hF throughout -> only requester 2 data summed; res_data=24, res_id=2; 8 accepts span 15 cycles.
4. Job done, res_ready=0 for 5 cycles -> res_valid/res_data/res_id stable for all 5; gnt stays 0 despite pending req=0010; grant issues only after handshake.
5. Reset pulsed after 4 accepted operands -> all outputs 0 on reset assertion; after release with req=0001 a fresh job of eight 1s gives res_data=8.
6. (RR_SUM_TIMEOUT_EN) 3 operands of 5, then op_valid low for 16 cycles -> res_valid=1, res_err=1, res_data=15; next requester granted after handshake.
